reg_viewer: RTL and testbench

Board-level register viewer that sits downstream of the pipelined CPU top. It drives that top's `reg_sel` register-select input and consumes its `reg_data` output. The selected 32-bit architectural register is shown as 8 hex digits on a multiplexed 8-digit common-anode 7-segment display. The selection is stepped by a debounced pushbutton or by an automatic timer.

---
 rtl/viewer_pkg.sv | 34 +++
 rtl/btn_debounce.sv | 49 ++++
 rtl/reg_viewer.sv | 112 +++++++++++
 tb/tb_reg_viewer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/viewer_pkg.sv
// Shared constants and the hex-to-7-segment decode for the register viewer.
package viewer_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int REG_IDX_W  = 5;
  localparam int DIGIT_W    = $clog2(NUM_DIGITS);

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Active-low segment pattern, bit order g..a.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton synchroniser and debouncer with a registered rising-edge pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_raw,
  output logic btn_db,
  output logic rise
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             btn_db_reg;
  logic             btn_db_d_reg;
  logic             rise_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_reg     <= 2'b00;
      cnt_reg      <= '0;
      btn_db_reg   <= 1'b0;
      btn_db_d_reg <= 1'b0;
      rise_reg     <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[0], btn_raw};
      btn_db_d_reg <= btn_db_reg;
      rise_reg     <= btn_db_reg & ~btn_db_d_reg;
      // Accept a new level only after it has been stable for DEB_CYCLES cycles.
      if (sync_reg[1] != btn_db_reg) begin
        if (cnt_reg == CNT_LAST) begin
          btn_db_reg <= sync_reg[1];
          cnt_reg    <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign btn_db = btn_db_reg;
  assign rise   = rise_reg;

endmodule

// File: rtl/reg_viewer.sv
// Steps the CPU register select and shows the selected 32-bit value on a
// multiplexed 8-digit common-anode 7-segment display.
module reg_viewer
  import viewer_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int AUTO_DIV   = 50000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        btn_next,
  input  logic        auto_en,
  input  logic        freeze,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic [7:0]  seg_n,
  output logic [7:0]  an_n
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int AUTO_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_DIV - 1);

  logic                 btn_db;
  logic                 step_man;
  logic                 step_auto;
  logic                 step;
  logic [REG_IDX_W-1:0] reg_sel_reg;
  logic [31:0]          disp_val_reg;
  logic [SCAN_W-1:0]    scan_cnt_reg;
  logic [AUTO_W-1:0]    auto_cnt_reg;
  logic [DIGIT_W-1:0]   digit_reg;
  logic [7:0]           seg_reg;
  logic [7:0]           an_reg;
  logic [7:0]           an_next;
  logic [7:0]           seg_next;
  logic [3:0]           nibble;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .rstn   (rstn),
    .btn_raw(btn_next),
    .btn_db (btn_db),
    .rise   (step_man)
  );

  assign step_auto = auto_en && (auto_cnt_reg == AUTO_LAST);
  // Coincident manual and auto steps collapse into a single increment.
  assign step      = step_man | step_auto;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      auto_cnt_reg <= '0;
      reg_sel_reg  <= '0;
      disp_val_reg <= '0;
    end else begin
      if (!auto_en || auto_cnt_reg == AUTO_LAST) begin
        auto_cnt_reg <= '0;
      end else begin
        auto_cnt_reg <= auto_cnt_reg + AUTO_W'(1);
      end
      if (step) begin
        reg_sel_reg <= reg_sel_reg + REG_IDX_W'(1);
      end
      if (!freeze) begin
        disp_val_reg <= reg_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scan_cnt_reg <= '0;
      digit_reg    <= '0;
    end else if (scan_cnt_reg == SCAN_LAST) begin
      scan_cnt_reg <= '0;
      digit_reg    <= digit_reg + DIGIT_W'(1);
    end else begin
      scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
      assign an_next[gi] = (digit_reg != DIGIT_W'(gi));
    end
  endgenerate

  assign nibble   = disp_val_reg[{digit_reg, 2'b00} +: 4];
  // The decimal point of digit 0 flags a frozen display.
  assign seg_next = {~(freeze && digit_reg == '0), hex7(nibble)};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seg_reg <= SEG_OFF;
      an_reg  <= SEG_OFF;
    end else begin
      seg_reg <= seg_next;
      an_reg  <= an_next;
    end
  end

  assign reg_sel = reg_sel_reg;
  assign seg_n   = seg_reg;
  assign an_n    = an_reg;

endmodule

// File: tb/tb_reg_viewer.sv
// Directed bench for reg_viewer with a scoreboard queue of expected values.
module tb_reg_viewer;

  logic        clk;
  logic        rstn;
  logic        btn_next;
  logic        auto_en;
  logic        freeze;
  logic [4:0]  reg_sel;
  logic [31:0] reg_data;
  logic [7:0]  seg_n;
  logic [7:0]  an_n;

  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  reg_viewer #(
    .SCAN_DIV  (4),
    .AUTO_DIV  (10),
    .DEB_CYCLES(3)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .btn_next(btn_next),
    .auto_en (auto_en),
    .freeze  (freeze),
    .reg_sel (reg_sel),
    .reg_data(reg_data),
    .seg_n   (seg_n),
    .an_n    (an_n)
  );

  // CPU register file stand-in.
  assign reg_data = {27'h0, reg_sel} ^ 32'hA5A5_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic wait_an(input string tag, input logic [7:0] target, input bit want_eq);
    int budget;
    budget = 0;
    while (((an_n == target) != want_eq) && budget < 100) begin
      tick(1);
      budget++;
    end
    if (budget >= 100) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s timeout waiting on an_n, observed=%h target=%h", tag, an_n, target);
    end
  endtask

  task automatic press();
    btn_next = 1'b1;
    tick(10);
    btn_next = 1'b0;
    tick(10);
  endtask

  initial begin
    int lit;
    rstn     = 1'b0;
    btn_next = 1'b0;
    auto_en  = 1'b0;
    freeze   = 1'b0;

    // Reset state
    tick(3);
    push(32'd0);   check("rst_reg_sel", {27'h0, reg_sel});
    push(32'hFF);  check("rst_an_n", {24'h0, an_n});
    push(32'hFF);  check("rst_seg_n", {24'h0, seg_n});
    rstn = 1'b1;
    tick(1);
    push(32'hFE);  check("first_an_n", {24'h0, an_n});
    wait_an("wait_digit4", 8'hEF, 1'b1);
    push(32'h92);  check("digit4_seg", {24'h0, seg_n});
    lit = 1;
    while (lit < 20) begin
      tick(1);
      if (an_n != 8'hEF) break;
      lit++;
    end
    push(32'd4);   check("digit_lit_cycles", lit);

    // Glitches must not step
    btn_next = 1'b1; tick(1); btn_next = 1'b0; tick(10);
    push(32'd0);   check("glitch1", {27'h0, reg_sel});
    btn_next = 1'b1; tick(2); btn_next = 1'b0; tick(10);
    push(32'd0);   check("glitch2", {27'h0, reg_sel});

    // Clean press: reg_sel changes on the seventh edge after the rise
    btn_next = 1'b1;
    tick(6);
    push(32'd0);   check("press_before", {27'h0, reg_sel});
    tick(1);
    push(32'd1);   check("press_step", {27'h0, reg_sel});
    tick(40);
    push(32'd1);   check("press_held", {27'h0, reg_sel});
    btn_next = 1'b0;
    tick(10);
    push(32'd1);   check("press_release", {27'h0, reg_sel});

    // Auto stepping up to 30, then across the wrap
    auto_en = 1'b1;
    tick(290);
    push(32'd30);  check("auto_reach30", {27'h0, reg_sel});
    for (int k = 1; k <= 33; k++) begin
      tick(9);
      push((30 + k - 1) % 32); check("auto_hold", {27'h0, reg_sel});
      tick(1);
      push((30 + k) % 32);     check("auto_step", {27'h0, reg_sel});
    end
    auto_en = 1'b0;
    tick(20);
    push(32'd31);  check("auto_off", {27'h0, reg_sel});

    // Coincident manual and auto step
    auto_en = 1'b1;
    tick(3);
    btn_next = 1'b1;
    tick(7);
    auto_en = 1'b0;
    push(32'd0);   check("coincident", {27'h0, reg_sel});
    tick(15);
    push(32'd0);   check("coincident_after", {27'h0, reg_sel});
    btn_next = 1'b0;
    tick(10);

    // Freeze holds the display while reg_sel keeps stepping
    press(); press(); press();
    push(32'd3);   check("pre_freeze", {27'h0, reg_sel});
    freeze = 1'b1;
    tick(2);
    press(); press();
    push(32'd5);   check("frozen_reg_sel", {27'h0, reg_sel});
    wait_an("wait_frozen_d0", 8'hFE, 1'b1);
    push(32'h30);  check("frozen_digit0", {24'h0, seg_n});
    freeze = 1'b0;
    wait_an("wait_leave_d0", 8'hFE, 1'b0);
    wait_an("wait_thawed_d0", 8'hFE, 1'b1);
    push(32'h92);  check("thawed_digit0", {24'h0, seg_n});

    // Asynchronous reset in the middle of a debounce
    press(); press();
    push(32'd7);   check("pre_reset", {27'h0, reg_sel});
    btn_next = 1'b1;
    tick(3);
    rstn = 1'b0;
    #1;
    push(32'd0);   check("mid_rst_reg_sel", {27'h0, reg_sel});
    push(32'hFF);  check("mid_rst_an_n", {24'h0, an_n});
    push(32'hFF);  check("mid_rst_seg_n", {24'h0, seg_n});
    btn_next = 1'b0;
    tick(3);
    rstn = 1'b1;
    tick(20);
    push(32'd0);   check("post_rst_no_step", {27'h0, reg_sel});
    push(32'd1);   check("post_rst_onehot", $countones(~an_n));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
